// File: rtl/inv_share_arbiter.sv
// Round-robin arbiter sharing one combinational inverter among NUM_REQ requesters.
// Each accepted operand is driven, settled, captured and returned tagged with its requester ID.
module inv_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 1,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         inv_a,
    input  logic [WIDTH-1:0]         inv_y,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);

    typedef enum logic [1:0] {StIdle, StDrive, StCapture, StRespond} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  inv_a_q, inv_a_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [NUM_REQ-1:0] grant;

    // Scan starting at rr_ptr so the last-served requester is considered last.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && (state_q == StIdle) && !rst) begin
            grant = NUM_REQ'(1) << winner;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_id_d    = rsp_id_q;
        inv_a_d     = inv_a_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (|(grant & req_valid)) begin
                    inv_a_d  = req_data[winner*WIDTH +: WIDTH];
                    rsp_id_d = winner;
                    rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    state_d  = StDrive;
                end
            end
            StDrive: state_d = StCapture;
            StCapture: begin
                rsp_data_d  = inv_y;
                rsp_valid_d = 1'b1;
                state_d     = StRespond;
            end
            StRespond: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            inv_a_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_id_q    <= rsp_id_d;
            inv_a_q     <= inv_a_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = grant;
    assign inv_a     = inv_a_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Bench for inv_share_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of grant order and response timing.
module tb_inv_share_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_data = '0;
    logic [3:0] req_ready;
    logic       inv_a;
    logic       inv_y;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       rsp_data;
    logic       rsp_ready = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int grants[$];

    // Transaction model: since < 0 means idle, otherwise cycles since the accept edge.
    int   m_ptr = 0;
    int   m_since = -1;
    logic m_inv_a = 1'b0;
    int   m_id = 0;
    logic m_data = 1'b0;
    logic m_rv = 1'b0;
    int   last_grant = -1;

    assign inv_y = ~inv_a;

    always #5 clk = ~clk;

    inv_share_arbiter #(.NUM_REQ(4), .WIDTH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .inv_a     (inv_a),
        .inv_y     (inv_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (rst || m_since >= 0) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs set; checks at +2, then advances model on the edge.
    task automatic step();
        int w;
        logic [3:0] er;
        #2;
        w  = model_winner();
        er = (w >= 0) ? 4'(1 << w) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("inv_a", 32'(inv_a), 32'(m_inv_a));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_since >= 0));
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                grants.push_back(i);
                break;
            end
        end
        @(posedge clk);
        last_grant = -1;
        if (rst) begin
            m_ptr = 0; m_since = -1; m_inv_a = 1'b0; m_id = 0; m_data = 1'b0; m_rv = 1'b0;
        end else if (m_since < 0) begin
            if (w >= 0) begin
                m_inv_a = req_data[w]; m_id = w; m_ptr = (w + 1) % N; m_since = 0;
                last_grant = w;
            end
        end else if (m_since == 0) begin
            m_since = 1;
        end else if (m_since == 1) begin
            m_data = ~m_inv_a; m_rv = 1'b1; m_since = 2;
        end else if (rsp_ready) begin
            m_rv = 1'b0; m_since = -1;
        end
        #1;
    endtask

    task automatic run_until_grants(input int want, input int budget);
        int n = 0;
        while (grants.size() < want && n < budget) begin
            step();
            n++;
        end
        chk("grant_count", 32'(grants.size()), 32'(want));
    endtask

    initial begin
        int exp_rr[6];
        exp_rr = '{0, 1, 2, 3, 0, 1};

        // Reset for two cycles, then idle.
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Single request from requester 2.
        req_valid = 4'b0100; req_data = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        #0;
        step();
        chk("single_inv_a", 32'(inv_a), 32'h1);
        req_valid = '0;
        step();
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        chk("single_rsp_data", 32'(rsp_data), 32'h0);
        rsp_ready = 1'b1;
        step();
        chk("single_idle", 32'(busy), 32'h0);

        // Round robin from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        req_valid = 4'b1111; req_data = 4'b1010;
        run_until_grants(6, 40);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(exp_rr[i]));
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) step();

        // Backpressure: others waiting while the response is held.
        req_valid = 4'b0010; req_data = 4'b0000; rsp_ready = 1'b0;
        step();
        req_valid = 4'b1101;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_data", 32'(rsp_data), 32'h1);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        req_valid = '0; rsp_ready = 1'b1;
        step();
        chk("bp_consumed", 32'(rsp_valid), 32'h0);
        for (int i = 0; i < 3; i++) step();

        // Wrap: serve requester 3, then 0 and 3 both request.
        req_valid = 4'b1000; req_data = 4'b1000;
        step();
        req_valid = '0;
        for (int i = 0; i < 3; i++) step();
        grants.delete();
        req_valid = 4'b1001; req_data = 4'b0001;
        run_until_grants(2, 20);
        if (grants.size() >= 2) begin
            chk("wrap_first", 32'(grants[0]), 32'h0);
            chk("wrap_second", 32'(grants[1]), 32'h3);
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) step();

        // Reset while in CAPTURE after serving requester 1.
        req_valid = 4'b0010; req_data = 4'b0010;
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_inv_a", 32'(inv_a), 32'h0);
        grants.delete();
        req_valid = 4'b1111;
        step();
        chk("abort_ptr_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'h0);
        req_valid = '0;
        for (int i = 0; i < 6; i++) step();

        // Random traffic with legal requester behaviour.
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 59) == 0);
            step();
            if (last_grant >= 0) req_data[last_grant] = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
